// File: rtl/led_pkg.sv
// Shared constants for the LED pattern controller: pattern modes,
// register addresses and CTRL field positions.
// Latency: n/a (declarations only). Backpressure: n/a.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_SCAN   = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_MODE_MSB = 1;
  localparam int CTRL_BRT_LSB  = 2;
  localparam int CTRL_BRT_MSB  = 5;

  localparam logic [3:0] BRT_RESET = 4'hF;

endpackage

// File: rtl/led_tick.sv
// Pattern-tick prescaler: counts 0..TICK_DIV-1 and pulses tick on the last count.
// Latency: tick is combinational from the count register; clr takes effect next cycle.
// Backpressure: none; free-running, clr restarts the period.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the period (count returns to 0)
//   tick       : one-cycle pulse every TICK_DIV cycles
module led_tick #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int             CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_sched.sv
// Memory-mapped LED pattern controller: DIRECT / COUNT / SCAN / BLINK on the LED count bus.
// Latency: register writes reach count one cycle after the write edge; pattern steps one cycle after a tick.
// Backpressure: none; every cpu_we write is accepted.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   cpu_we/addr/din    : write strobe, register select (0 DATA, 1 CTRL), write data
//   cpu_dout           : combinational read data for cpu_addr
//   count              : registered LED pattern
// Build option: define LED_PWM_EN to compile in per-LED brightness gating (CTRL[5:2]).
module led_sched
  import led_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int WIDTH    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_we,
  input  logic             cpu_addr,
  input  logic [15:0]      cpu_din,
  output logic [15:0]      cpu_dout,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] SCAN_LO = WIDTH'(1);
  localparam logic [WIDTH-1:0] SCAN_HI = WIDTH'(1) << (WIDTH - 1);

  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] scan_q, scan_d;
  logic             scan_left_q, scan_left_d;
  logic             blink_on_q, blink_on_d;
  logic [WIDTH-1:0] count_q, count_d;

  logic             tick;
  logic             ctrl_wr, data_wr;
  logic [WIDTH-1:0] scan_shift;
  logic [WIDTH-1:0] pat_cur, pat_next;
  logic             pwm_gate;
  logic [3:0]       bright_rb;
  logic             unused_din;

  assign ctrl_wr    = cpu_we && (cpu_addr == ADDR_CTRL);
  assign data_wr    = cpu_we && (cpu_addr == ADDR_DATA);
  assign unused_din = ^cpu_din[15:WIDTH];

  // A CTRL write restarts the tick period so the first step lands a full period later.
  led_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ctrl_wr),
    .tick  (tick)
  );

  function automatic logic [WIDTH-1:0] pattern_of(
    input mode_e            m,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] c,
    input logic [WIDTH-1:0] s,
    input logic             on
  );
    pattern_of = d;
    case (m)
      MODE_DIRECT: pattern_of = d;
      MODE_COUNT:  pattern_of = c;
      MODE_SCAN:   pattern_of = s;
      MODE_BLINK:  pattern_of = on ? d : '0;
      default:     pattern_of = d;
    endcase
  endfunction

  always_comb begin
    mode_d      = mode_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    scan_d      = scan_q;
    scan_left_d = scan_left_q;
    blink_on_d  = blink_on_q;
    scan_shift  = scan_left_q ? (scan_q << 1) : (scan_q >> 1);

    if (ctrl_wr) begin
      // Any CTRL write (even the same mode) reloads every pattern and drops a coincident tick.
      mode_d      = mode_e'(cpu_din[CTRL_MODE_MSB:CTRL_MODE_LSB]);
      cnt_d       = data_q;
      scan_d      = SCAN_LO;
      scan_left_d = 1'b1;
      blink_on_d  = 1'b1;
    end else begin
      if (data_wr) begin
        data_d = cpu_din[WIDTH-1:0];
      end
      // In COUNT mode a DATA write beats a coincident tick.
      if (data_wr && mode_q == MODE_COUNT) begin
        cnt_d = cpu_din[WIDTH-1:0];
      end else if (tick) begin
        case (mode_q)
          MODE_COUNT: cnt_d = cnt_q + WIDTH'(1);
          MODE_SCAN: begin
            // Reverse on reaching an end so each end position is held for one tick only.
            scan_d = scan_shift;
            if (scan_shift == SCAN_HI) begin
              scan_left_d = 1'b0;
            end else if (scan_shift == SCAN_LO) begin
              scan_left_d = 1'b1;
            end
          end
          MODE_BLINK: blink_on_d = ~blink_on_q;
          default: ;
        endcase
      end
    end
  end

  assign pat_cur  = pattern_of(mode_q, data_q, cnt_q, scan_q, blink_on_q);
  assign pat_next = pattern_of(mode_d, data_d, cnt_d, scan_d, blink_on_d);

`ifdef LED_PWM_EN
  logic [3:0] pwm_q, pwm_d;
  logic [3:0] bright_q, bright_d;

  always_comb begin
    pwm_d    = pwm_q + 4'd1;
    bright_d = bright_q;
    if (ctrl_wr) begin
      bright_d = cpu_din[CTRL_BRT_MSB:CTRL_BRT_LSB];
    end
  end

  // Gate against the values the count register will see, keeping count fully registered.
  assign pwm_gate  = (pwm_d <= bright_d);
  assign bright_rb = bright_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q    <= '0;
      bright_q <= BRT_RESET;
    end else begin
      pwm_q    <= pwm_d;
      bright_q <= bright_d;
    end
  end
`else
  assign pwm_gate  = 1'b1;
  assign bright_rb = 4'h0;
`endif

  assign count_d = pat_next & {WIDTH{pwm_gate}};
  assign count   = count_q;

  always_comb begin
    cpu_dout = '0;
    if (cpu_addr == ADDR_DATA) begin
      cpu_dout[WIDTH-1:0] = pat_cur;
    end else begin
      cpu_dout[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_q;
      cpu_dout[CTRL_BRT_MSB:CTRL_BRT_LSB]   = bright_rb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_DIRECT;
      data_q      <= '0;
      cnt_q       <= '0;
      scan_q      <= SCAN_LO;
      scan_left_q <= 1'b1;
      blink_on_q  <= 1'b1;
      count_q     <= '0;
    end else begin
      mode_q      <= mode_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      scan_q      <= scan_d;
      scan_left_q <= scan_left_d;
      blink_on_q  <= blink_on_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_led_sched.sv
// Bench for led_sched with TICK_DIV=4: directed vector table, reset/PWM sequences,
// then random register traffic checked every cycle against a behavioural model.
module tb_led_sched;

  localparam int TD = 4;
`ifdef LED_PWM_EN
  localparam logic [15:0] BRT_RB   = 16'h003C;
  localparam logic [15:0] PWM_RB   = 16'h000C;
  localparam int          PWM_DUTY = 4;
`else
  localparam logic [15:0] BRT_RB   = 16'h0000;
  localparam logic [15:0] PWM_RB   = 16'h0000;
  localparam int          PWM_DUTY = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_we = 1'b0;
  logic        cpu_addr = 1'b0;
  logic [15:0] cpu_din = 16'h0;
  logic [15:0] cpu_dout;
  logic [7:0]  count;

  always #5 clk = ~clk;

  led_sched #(.TICK_DIV(TD), .WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .count    (count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Scan is a position index around a 14-step bounce: 0..7 then back down to 1.
  int m_data, m_mode, m_pre, m_cnt, m_sidx, m_on, m_bright, m_pwm;

  function automatic void model_reset();
    m_data = 0; m_mode = 0; m_pre = 0; m_cnt = 0;
    m_sidx = 0; m_on = 1; m_bright = 15; m_pwm = 0;
  endfunction

  function automatic int m_pattern();
    int pos;
    pos = (m_sidx < 8) ? m_sidx : 14 - m_sidx;
    case (m_mode)
      1:       return m_cnt;
      2:       return 1 << pos;
      3:       return m_on ? m_data : 0;
      default: return m_data;
    endcase
  endfunction

  function automatic void model_step(input logic we, input logic a, input logic [15:0] din);
    int tick;
    int cnt_written;
    tick  = (m_pre == TD - 1) ? 1 : 0;
    m_pwm = (m_pwm + 1) % 16;
    cnt_written = 0;
    if (we && a) begin
      m_mode = din % 4;
`ifdef LED_PWM_EN
      m_bright = (din / 4) % 16;
`endif
      m_pre = 0; m_cnt = m_data; m_sidx = 0; m_on = 1;
    end else begin
      m_pre = tick ? 0 : m_pre + 1;
      if (we) begin
        m_data = din % 256;
        if (m_mode == 1) begin
          m_cnt = m_data;
          cnt_written = 1;
        end
      end
      if (tick && !cnt_written) begin
        case (m_mode)
          1: m_cnt  = (m_cnt + 1) % 256;
          2: m_sidx = (m_sidx + 1) % 14;
          3: m_on   = 1 - m_on;
          default: ;
        endcase
      end
    end
  endfunction

  function automatic logic [7:0] m_exp_count();
`ifdef LED_PWM_EN
    return (m_pwm <= m_bright) ? 8'(m_pattern()) : 8'h00;
`else
    return 8'(m_pattern());
`endif
  endfunction

  function automatic logic [15:0] m_exp_dout(input logic a);
    if (!a) return 16'(m_pattern());
`ifdef LED_PWM_EN
    return 16'(m_bright * 4 + m_mode);
`else
    return 16'(m_mode);
`endif
  endfunction

  // One clock: drive at negedge, advance the model, sample at the next negedge.
  task automatic step(input logic we, input logic a, input logic [15:0] din);
    cpu_we = we; cpu_addr = a; cpu_din = din;
    model_step(we, a, din);
    @(posedge clk);
    @(negedge clk);
    check("model_count", {8'h00, count}, {8'h00, m_exp_count()});
    check("model_dout", cpu_dout, m_exp_dout(a));
    cpu_we = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we;
    logic        addr;
    logic [15:0] din;
    logic [7:0]  cnt;
    logic [15:0] dout;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic we, input logic a, input logic [15:0] din,
                              input logic [7:0] c, input logic [15:0] d);
    vec_t v;
    v.we = we; v.addr = a; v.din = din; v.cnt = c; v.dout = d;
    tbl.push_back(v);
  endfunction

  function automatic void idle(input int n, input logic [7:0] c);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 16'h0, c, {8'h00, c});
  endfunction

  // CTRL write value: brightness field set to full so patterns are ungated.
  function automatic logic [15:0] ctrl(input int m);
    return 16'(m) | 16'h003C;
  endfunction

  function automatic logic [15:0] ctrl_rb(input int m);
    return 16'(m) | BRT_RB;
  endfunction

  initial begin
    logic [7:0] scan_seq [15];
    int on_cycles;

    // Reset state
    rst_n = 1'b0;
    #12;
    check("rst_count", {8'h00, count}, 16'h0000);
    cpu_addr = 1'b1; #1;
    check("rst_ctrl_rd", cpu_dout, BRT_RB);
    cpu_addr = 1'b0; #1;
    check("rst_data_rd", cpu_dout, 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // DIRECT
    add(1, 0, 16'h00A5, 8'hA5, 16'h00A5);
    add(0, 0, 16'h0000, 8'hA5, 16'h00A5);
    add(1, 0, 16'h00FE, 8'hFE, 16'h00FE);
    // COUNT: first step four cycles after the CTRL write edge
    add(1, 1, ctrl(1), 8'hFE, ctrl_rb(1));
    idle(3, 8'hFE);
    idle(4, 8'hFF);
    idle(4, 8'h00);
    idle(4, 8'h01);
    // DATA write coinciding with a tick: load wins, no increment
    add(1, 0, 16'h0010, 8'h10, 16'h0010);
    idle(3, 8'h10);
    idle(1, 8'h11);
    // SCAN bounce
    add(1, 1, ctrl(2), 8'h01, ctrl_rb(2));
    idle(3, 8'h01);
    scan_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    for (int i = 0; i < 15; i++) idle(4, scan_seq[i]);
    // DATA write in SCAN lands on a tick: scan still advances, pattern unaffected by DATA
    add(1, 0, 16'h003C, 8'h04, 16'h0004);
    // BLINK
    add(1, 1, ctrl(3), 8'h3C, ctrl_rb(3));
    idle(3, 8'h3C);
    idle(4, 8'h00);
    idle(4, 8'h3C);
    idle(1, 8'h00);
    add(1, 0, 16'h000F, 8'h00, 16'h0000);
    idle(2, 8'h00);
    idle(4, 8'h0F);
    idle(4, 8'h00);

    foreach (tbl[i]) begin
      step(tbl[i].we, tbl[i].addr, tbl[i].din);
      check($sformatf("tbl%0d_count", i), {8'h00, count}, {8'h00, tbl[i].cnt});
      check($sformatf("tbl%0d_dout", i), cpu_dout, tbl[i].dout);
    end

    // Asynchronous reset mid-scan
    step(1, 1, ctrl(2));
    for (int i = 0; i < 9; i++) step(0, 0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_count", {8'h00, count}, 16'h0000);
    cpu_addr = 1'b1; #1;
    check("midrst_ctrl_rd", cpu_dout, BRT_RB);
    cpu_addr = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 16'h0);
    check("after_rst_count", {8'h00, count}, 16'h0000);

    // Brightness 3 in DIRECT with all LEDs on
    step(1, 0, 16'h00FF);
    step(1, 1, 16'h000C);
    check("pwm_ctrl_rd", cpu_dout, PWM_RB);
    on_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 16'h0);
      if (count == 8'hFF) on_cycles++;
    end
    check("pwm_duty", 16'(on_cycles), 16'(PWM_DUTY));

    // Random register traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0)      step(1, 1, 16'($urandom));
      else if (r < 4)  step(1, 0, 16'($urandom));
      else             step(0, 1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
